light_safety_monitor: RTL and testbench

- Sits directly downstream of the traffic-light controller and drives the physical lamp outputs.
- Registers street_a/street_b each cycle and checks them for illegal codes, conflicting right-of-way and stuck phases.
- On any fault it overrides the lamps with a flashing failsafe pattern until an operator clear is accepted.
- After a clear it forces all-red for a recovery interval, then returns to pass-through.

---
 rtl/light_safety_monitor.sv | 216 +++++++++++++++++++++
 tb/tb_light_safety_monitor.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/light_safety_monitor.sv
// light_safety_monitor
//
// Sits between the traffic-light controller and the physical lamp drivers.
// Every cycle the controller codes are registered into in_a/in_b and checked
// for illegal (non one-hot) codes, conflicting right-of-way and stuck
// patterns. Any fault replaces the lamps with a flashing failsafe pattern
// until an operator clear is accepted. After the clear, all-red is held for
// a recovery interval before pass-through resumes.
//
// Optional build macro:
//   LAMP_FAULT_RED_EN  - failsafe flash uses red (3'b100) instead of
//                        yellow (3'b010); timing is identical.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   synchronous active-high reset
//   street_a    in   [2:0] controller lamp code street A {red,yellow,green}
//   street_b    in   [2:0] controller lamp code street B
//   fault_clr   in   operator clear (pulse or level)
//   lamp_a      out  [2:0] registered lamp drive street A
//   lamp_b      out  [2:0] registered lamp drive street B
//   fault       out  high while in FAULT
//   fault_code  out  [1:0] cause of first fault: 0 none, 1 illegal,
//                    2 conflict, 3 stuck

module light_safety_monitor #(
    parameter int BLINK_DIV   = 25000000,
    parameter int WDOG_MAX    = 100000000,
    parameter int RECOVER_CYC = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] street_a,
    input  logic [2:0] street_b,
    input  logic       fault_clr,
    output logic [2:0] lamp_a,
    output logic [2:0] lamp_b,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int BLINK_W = $clog2(BLINK_DIV) + 1;
    localparam int WDOG_W  = $clog2(WDOG_MAX) + 1;
    localparam int REC_W   = $clog2(RECOVER_CYC) + 1;

    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [WDOG_W-1:0]  WDOG_LIMIT = WDOG_W'(WDOG_MAX);
    localparam logic [REC_W-1:0]   REC_LAST   = REC_W'(RECOVER_CYC - 1);

    localparam logic [2:0] ALL_RED  = 3'b100;
    localparam logic [2:0] LAMP_OFF = 3'b000;
`ifdef LAMP_FAULT_RED_EN
    localparam logic [2:0] FLASH_ON = 3'b100;
`else
    localparam logic [2:0] FLASH_ON = 3'b010;
`endif

    localparam logic [1:0] CODE_NONE     = 2'd0;
    localparam logic [1:0] CODE_ILLEGAL  = 2'd1;
    localparam logic [1:0] CODE_CONFLICT = 2'd2;
    localparam logic [1:0] CODE_STUCK    = 2'd3;

    typedef enum logic [1:0] {
        ST_NORMAL,
        ST_FAULT,
        ST_RECOVER
    } state_t;

    state_t             state, state_n;
    logic [2:0]         in_a, in_b;
    logic [WDOG_W-1:0]  wdog_cnt;
    logic [BLINK_W-1:0] blink_cnt, blink_cnt_n;
    logic               blink_on, blink_on_n;
    logic [REC_W-1:0]   rec_cnt, rec_cnt_n;
    logic [2:0]         lamp_a_n, lamp_b_n;
    logic               fault_n;
    logic [1:0]         fault_code_n;

    logic               chk_illegal, chk_conflict, chk_stuck, chk_any;
    logic [1:0]         chk_cause;

    // Input capture and watchdog. The watchdog compares the value about to
    // be captured with the one currently held, so wdog_cnt always tells how
    // many consecutive repeats the pattern now in in_a/in_b has had.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_a     <= ALL_RED;
            in_b     <= ALL_RED;
            wdog_cnt <= '0;
        end else begin
            in_a <= street_a;
            in_b <= street_b;
            if ({street_a, street_b} != {in_a, in_b}) begin
                wdog_cnt <= '0;
            end else if (wdog_cnt != WDOG_LIMIT) begin
                wdog_cnt <= wdog_cnt + WDOG_W'(1);
            end
        end
    end

    // Checks on the registered pattern; illegal wins over conflict, which
    // wins over stuck.
    always_comb begin
        chk_illegal  = !$onehot(in_a) || !$onehot(in_b);
        chk_conflict = (in_a != ALL_RED) && (in_b != ALL_RED);
        chk_stuck    = (wdog_cnt == WDOG_LIMIT);
        chk_any      = chk_illegal || chk_conflict || chk_stuck;
        chk_cause    = CODE_NONE;
        if (chk_illegal) begin
            chk_cause = CODE_ILLEGAL;
        end else if (chk_conflict) begin
            chk_cause = CODE_CONFLICT;
        end else if (chk_stuck) begin
            chk_cause = CODE_STUCK;
        end
    end

    // State register plus all registered outputs and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_NORMAL;
            lamp_a     <= ALL_RED;
            lamp_b     <= ALL_RED;
            fault      <= 1'b0;
            fault_code <= CODE_NONE;
            blink_cnt  <= '0;
            blink_on   <= 1'b0;
            rec_cnt    <= '0;
        end else begin
            state      <= state_n;
            lamp_a     <= lamp_a_n;
            lamp_b     <= lamp_b_n;
            fault      <= fault_n;
            fault_code <= fault_code_n;
            blink_cnt  <= blink_cnt_n;
            blink_on   <= blink_on_n;
            rec_cnt    <= rec_cnt_n;
        end
    end

    // Next-state logic. Fault entry loads the lit flash pattern on the same
    // edge, so a faulty pattern never reaches the lamps. blink_cnt counts
    // cycles already spent in the current flash half-period.
    always_comb begin
        state_n      = state;
        lamp_a_n     = lamp_a;
        lamp_b_n     = lamp_b;
        fault_n      = fault;
        fault_code_n = fault_code;
        blink_cnt_n  = blink_cnt;
        blink_on_n   = blink_on;
        rec_cnt_n    = rec_cnt;

        case (state)
            ST_NORMAL: begin
                if (chk_any) begin
                    state_n      = ST_FAULT;
                    fault_n      = 1'b1;
                    fault_code_n = chk_cause;
                    lamp_a_n     = FLASH_ON;
                    lamp_b_n     = FLASH_ON;
                    blink_cnt_n  = '0;
                    blink_on_n   = 1'b1;
                end else begin
                    lamp_a_n = in_a;
                    lamp_b_n = in_b;
                end
            end

            ST_FAULT: begin
                if (fault_clr && !chk_any) begin
                    state_n      = ST_RECOVER;
                    fault_n      = 1'b0;
                    fault_code_n = CODE_NONE;
                    lamp_a_n     = ALL_RED;
                    lamp_b_n     = ALL_RED;
                    rec_cnt_n    = '0;
                end else begin
                    if (blink_cnt == BLINK_LAST) begin
                        blink_cnt_n = '0;
                        blink_on_n  = !blink_on;
                    end else begin
                        blink_cnt_n = blink_cnt + BLINK_W'(1);
                    end
                    lamp_a_n = blink_on_n ? FLASH_ON : LAMP_OFF;
                    lamp_b_n = blink_on_n ? FLASH_ON : LAMP_OFF;
                end
            end

            ST_RECOVER: begin
                if (chk_any) begin
                    state_n      = ST_FAULT;
                    fault_n      = 1'b1;
                    fault_code_n = chk_cause;
                    lamp_a_n     = FLASH_ON;
                    lamp_b_n     = FLASH_ON;
                    blink_cnt_n  = '0;
                    blink_on_n   = 1'b1;
                end else if (rec_cnt == REC_LAST) begin
                    state_n  = ST_NORMAL;
                    lamp_a_n = in_a;
                    lamp_b_n = in_b;
                end else begin
                    rec_cnt_n = rec_cnt + REC_W'(1);
                    lamp_a_n  = ALL_RED;
                    lamp_b_n  = ALL_RED;
                end
            end

            default: begin
                state_n = ST_NORMAL;
            end
        endcase
    end

endmodule

// File: tb/tb_light_safety_monitor.sv
// tb_light_safety_monitor
//
// Self-checking bench for light_safety_monitor with BLINK_DIV=4,
// WDOG_MAX=20, RECOVER_CYC=6. A hand-computed vector table covers pass-
// through latency, illegal-code fault, flash timing, clear and recovery.
// Short directed sequences cover conflict, priority, stuck, rejected clear,
// re-fault during recovery and reset mid-fault. A random phase is checked
// cycle by cycle against a behavioural model. Honors LAMP_FAULT_RED_EN.

module tb_light_safety_monitor;

    localparam int BLINK_DIV   = 4;
    localparam int WDOG_MAX    = 20;
    localparam int RECOVER_CYC = 6;

`ifdef LAMP_FAULT_RED_EN
    localparam logic [2:0] FLASH = 3'b100;
`else
    localparam logic [2:0] FLASH = 3'b010;
`endif

    logic       clk;
    logic       rst;
    logic [2:0] street_a, street_b;
    logic       fault_clr;
    logic [2:0] lamp_a, lamp_b;
    logic       fault;
    logic [1:0] fault_code;

    int vectors_applied = 0;
    int miscompares     = 0;

    light_safety_monitor #(
        .BLINK_DIV  (BLINK_DIV),
        .WDOG_MAX   (WDOG_MAX),
        .RECOVER_CYC(RECOVER_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .street_a  (street_a),
        .street_b  (street_b),
        .fault_clr (fault_clr),
        .lamp_a    (lamp_a),
        .lamp_b    (lamp_b),
        .fault     (fault),
        .fault_code(fault_code)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model: mode 0 normal, 1 fault, 2 recover. m_run is the
    // length of the current run of identical registered patterns; m_since
    // counts edges since entering fault or recovery.
    int         m_mode;
    logic [2:0] m_in_a, m_in_b, m_lamp_a, m_lamp_b;
    int         m_run;
    int         m_since;
    logic       m_fault;
    logic [1:0] m_code;

    function automatic bit is_onehot(input logic [2:0] v);
        return $countones(v) == 1;
    endfunction

    task automatic model_enter_fault(input int cause);
        m_mode   = 1;
        m_since  = 0;
        m_fault  = 1'b1;
        m_code   = 2'(cause);
        m_lamp_a = FLASH;
        m_lamp_b = FLASH;
    endtask

    task automatic model_edge(input logic [2:0] sa, input logic [2:0] sb,
                              input logic clr, input logic r);
        int cause;
        if (r) begin
            m_mode = 0; m_in_a = 3'b100; m_in_b = 3'b100;
            m_lamp_a = 3'b100; m_lamp_b = 3'b100;
            m_fault = 1'b0; m_code = 2'd0; m_run = 1; m_since = 0;
            return;
        end
        cause = 0;
        if (!is_onehot(m_in_a) || !is_onehot(m_in_b)) cause = 1;
        else if (m_in_a != 3'b100 && m_in_b != 3'b100) cause = 2;
        else if (m_run - 1 >= WDOG_MAX) cause = 3;

        case (m_mode)
            0: begin
                if (cause != 0) model_enter_fault(cause);
                else begin
                    m_lamp_a = m_in_a;
                    m_lamp_b = m_in_b;
                end
            end
            1: begin
                if (clr && cause == 0) begin
                    m_mode = 2; m_since = 0; m_fault = 1'b0; m_code = 2'd0;
                    m_lamp_a = 3'b100; m_lamp_b = 3'b100;
                end else begin
                    m_since++;
                    m_lamp_a = ((m_since / BLINK_DIV) % 2 == 0) ? FLASH : 3'b000;
                    m_lamp_b = m_lamp_a;
                end
            end
            default: begin
                if (cause != 0) model_enter_fault(cause);
                else begin
                    m_since++;
                    if (m_since == RECOVER_CYC) begin
                        m_mode = 0;
                        m_lamp_a = m_in_a;
                        m_lamp_b = m_in_b;
                    end else begin
                        m_lamp_a = 3'b100;
                        m_lamp_b = 3'b100;
                    end
                end
            end
        endcase

        if ({sa, sb} == {m_in_a, m_in_b}) begin
            if (m_run < WDOG_MAX + 5) m_run++;
        end else begin
            m_run = 1;
        end
        m_in_a = sa;
        m_in_b = sb;
    endtask

    // Drive one cycle of inputs, advance the model on the edge, then settle.
    task automatic apply_stimulus(input logic [2:0] sa, input logic [2:0] sb,
                                  input logic clr, input logic r);
        street_a  = sa;
        street_b  = sb;
        fault_clr = clr;
        rst       = r;
        @(posedge clk);
        model_edge(sa, sb, clr, r);
        #1;
    endtask

    task automatic check_output(input string name);
        vectors_applied++;
        if ({lamp_a, lamp_b, fault, fault_code} !==
            {m_lamp_a, m_lamp_b, m_fault, m_code}) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got lamp_a=%b lamp_b=%b fault=%b code=%0d, expected lamp_a=%b lamp_b=%b fault=%b code=%0d",
                     name, $time, lamp_a, lamp_b, fault, fault_code,
                     m_lamp_a, m_lamp_b, m_fault, m_code);
        end
    endtask

    task automatic check_value(input string name, input logic [8:0] act,
                               input logic [8:0] exp);
        vectors_applied++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s @%0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    task automatic step_checked(input logic [2:0] sa, input logic [2:0] sb,
                                input logic clr, input logic r, input string name);
        apply_stimulus(sa, sb, clr, r);
        check_output(name);
    endtask

    typedef struct {
        logic [2:0] sa;
        logic [2:0] sb;
        logic       clr;
        logic       r;
        logic [2:0] exp_a;
        logic [2:0] exp_b;
        logic       exp_fault;
        logic [1:0] exp_code;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [2:0] cur_a, cur_b;
        logic [2:0] onehots [3];
        int hold_left;
        int pick;

        onehots[0] = 3'b001; onehots[1] = 3'b010; onehots[2] = 3'b100;
        street_a = 3'b100; street_b = 3'b100; fault_clr = 1'b0; rst = 1'b1;

        // Hand-computed table: reset, pass-through, illegal fault, flash,
        // clear, six all-red cycles, pass-through again.
        vecs.push_back('{3'b001, 3'b100, 1'b0, 1'b1, 3'b100, 3'b100, 1'b0, 2'd0});
        vecs.push_back('{3'b001, 3'b100, 1'b0, 1'b0, 3'b100, 3'b100, 1'b0, 2'd0});
        vecs.push_back('{3'b001, 3'b100, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 2'd0});
        vecs.push_back('{3'b011, 3'b100, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 2'd0});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{3'b001, 3'b100, 1'b0, 1'b0, FLASH, FLASH, 1'b1, 2'd1});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{3'b001, 3'b100, 1'b0, 1'b0, 3'b000, 3'b000, 1'b1, 2'd1});
        vecs.push_back('{3'b001, 3'b100, 1'b0, 1'b0, FLASH, FLASH, 1'b1, 2'd1});
        vecs.push_back('{3'b001, 3'b100, 1'b1, 1'b0, 3'b100, 3'b100, 1'b0, 2'd0});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{3'b001, 3'b100, 1'b0, 1'b0, 3'b100, 3'b100, 1'b0, 2'd0});
        vecs.push_back('{3'b001, 3'b100, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 2'd0});
        vecs.push_back('{3'b100, 3'b001, 1'b0, 1'b0, 3'b001, 3'b100, 1'b0, 2'd0});
        vecs.push_back('{3'b100, 3'b001, 1'b0, 1'b0, 3'b100, 3'b001, 1'b0, 2'd0});

        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].sa, vecs[i].sb, vecs[i].clr, vecs[i].r);
            check_output($sformatf("model_row%0d", i));
            check_value($sformatf("table_row%0d", i),
                        {vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_fault, vecs[i].exp_code},
                        {lamp_a, lamp_b, fault, fault_code});
        end

        // Conflict, then clears rejected while the conflict persists.
        for (int i = 0; i < 3; i++) step_checked(3'b001, 3'b001, 1'b0, 1'b0, "conflict");
        check_value("conflict_code", 9'({fault, fault_code}), 9'({1'b1, 2'd2}));
        for (int i = 0; i < 3; i++) step_checked(3'b001, 3'b001, 1'b1, 1'b0, "reject_clr");
        check_value("reject_clr_code", 9'({fault, fault_code}), 9'({1'b1, 2'd2}));

        // Fix input, clear, then conflict during recovery re-faults.
        for (int i = 0; i < 2; i++) step_checked(3'b100, 3'b010, 1'b0, 1'b0, "fix_input");
        step_checked(3'b100, 3'b010, 1'b1, 1'b0, "accept_clr");
        check_value("accept_clr_out", {lamp_a, lamp_b, fault, fault_code},
                    {3'b100, 3'b100, 1'b0, 2'd0});
        for (int i = 0; i < 3; i++) step_checked(3'b001, 3'b001, 1'b0, 1'b0, "recover_conflict");
        check_value("recover_conflict_code", 9'({fault, fault_code}), 9'({1'b1, 2'd2}));

        // Reset dominates mid-fault.
        step_checked(3'b001, 3'b001, 1'b0, 1'b1, "rst_mid_fault");
        check_value("rst_mid_fault_out", {lamp_a, lamp_b, fault, fault_code},
                    {3'b100, 3'b100, 1'b0, 2'd0});

        // Illegal and conflict together: illegal wins.
        for (int i = 0; i < 3; i++) step_checked(3'b101, 3'b001, 1'b0, 1'b0, "priority");
        check_value("priority_code", 9'({fault, fault_code}), 9'({1'b1, 2'd1}));
        step_checked(3'b100, 3'b100, 1'b0, 1'b1, "rst_after_priority");

        // Stuck pattern, then a later illegal code must not overwrite the code.
        for (int i = 0; i < 21; i++) step_checked(3'b010, 3'b100, 1'b0, 1'b0, "stuck_hold");
        check_value("stuck_not_yet", 9'(fault), 9'(1'b0));
        for (int i = 0; i < 3; i++) step_checked(3'b010, 3'b100, 1'b0, 1'b0, "stuck_hold");
        check_value("stuck_code", 9'({fault, fault_code}), 9'({1'b1, 2'd3}));
        for (int i = 0; i < 3; i++) step_checked(3'b111, 3'b100, 1'b0, 1'b0, "code_held");
        check_value("code_held", 9'({fault, fault_code}), 9'({1'b1, 2'd3}));
        step_checked(3'b100, 3'b100, 1'b0, 1'b1, "rst_before_random");

        // Randomized phase against the model.
        cur_a = 3'b100; cur_b = 3'b001; hold_left = 0;
        for (int n = 0; n < 3000; n++) begin
            if (hold_left > 0) begin
                hold_left--;
            end else begin
                pick = $urandom_range(0, 99);
                if (pick < 65) begin
                    if ($urandom_range(0, 1) == 0) begin
                        cur_a = 3'b100; cur_b = onehots[$urandom_range(0, 2)];
                    end else begin
                        cur_a = onehots[$urandom_range(0, 2)]; cur_b = 3'b100;
                    end
                end else if (pick < 78) begin
                    cur_a = onehots[$urandom_range(0, 1)];
                    cur_b = onehots[$urandom_range(0, 1)];
                end else if (pick < 86) begin
                    cur_a = 3'($urandom_range(0, 7));
                    cur_b = 3'($urandom_range(0, 7));
                end else if (pick < 89) begin
                    hold_left = $urandom_range(18, 26);
                end
            end
            apply_stimulus(cur_a, cur_b, ($urandom_range(0, 3) == 0),
                           ($urandom_range(0, 199) == 0));
            check_output("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
